mem_arbiter: RTL and testbench

Two-port arbiter in front of the single-port 512x32 block-RAM program/data memory. Port 0 is the P12 CPU bus. Port 1 is a secondary master (debug monitor / loader). Each access runs through an IDLE/ACC/RSP sequence. The block drives RAM chip-select, write-enable, address and write data, and returns read data per port. Addresses outside the RAM window are answered with an error, not forwarded.

---
 rtl/memarb_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/memarb_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/memarb_pkg.sv
// memarb_pkg: shared types and defaults for the two-port block-RAM arbiter.
// Holds the FSM state encoding, the port-index type and default widths.
package memarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    // Index of a requesting port: 0 = CPU bus, 1 = debug monitor / loader
    typedef logic port_t;

    localparam int DEF_AW     = 32;
    localparam int DEF_DW     = 32;
    localparam int DEF_RAM_AW = 9;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: both requester ports plus the RAM-side bus of the arbiter.
// The slave modport is the arbiter's view, master is the surrounding system
// (requesters and the RAM itself).
interface mem_arbiter_if #(
    parameter int AW     = memarb_pkg::DEF_AW,
    parameter int DW     = memarb_pkg::DEF_DW,
    parameter int RAM_AW = memarb_pkg::DEF_RAM_AW
);

    logic              req0;
    logic              wr0;
    logic [AW-1:0]     a0;
    logic [DW-1:0]     i0;
    logic              ack0;
    logic              err0;
    logic [DW-1:0]     o0;

    logic              req1;
    logic              wr1;
    logic [AW-1:0]     a1;
    logic [DW-1:0]     i1;
    logic              ack1;
    logic              err1;
    logic [DW-1:0]     o1;

    logic              mcs;
    logic              mwr;
    logic [RAM_AW-1:0] ma;
    logic [DW-1:0]     mi;
    logic [DW-1:0]     mo;

    modport slave (
        input  req0, wr0, a0, i0,
        input  req1, wr1, a1, i1,
        input  mo,
        output ack0, err0, o0,
        output ack1, err1, o1,
        output mcs, mwr, ma, mi
    );

    modport master (
        output req0, wr0, a0, i0,
        output req1, wr1, a1, i1,
        output mo,
        input  ack0, err0, o0,
        input  ack1, err1, o1,
        input  mcs, mwr, ma, mi
    );

endinterface

// File: rtl/memarb_pick.sv
// memarb_pick: combinational winner selection between the two requesters.
// Optional feature macro: MEMARB_ROUND_ROBIN_EN (round-robin on ties);
// when undefined, port 0 has fixed priority.
module memarb_pick
    import memarb_pkg::*;
(
    input  logic  req0,
    input  logic  req1,
    input  port_t last,
    output port_t win,
    output logic  any_req
);

    assign any_req = req0 | req1;

`ifdef MEMARB_ROUND_ROBIN_EN
    // On a tie the port that was not served last wins; a lone requester always wins
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = ~last;
        end else begin
            win = ~req0;
        end
    end
`else
    // Fixed priority: port 0 wins whenever it requests; the history bit is not needed
    logic unused_last;
    assign unused_last = last;
    assign win         = ~req0;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single-port synchronous block RAM.
// Each access runs IDLE -> ACC -> RSP; out-of-window addresses get ERR
// instead of a RAM cycle. Winner selection lives in memarb_pick and follows
// the MEMARB_ROUND_ROBIN_EN macro (fixed port-0 priority when undefined).
module mem_arbiter
    import memarb_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RAM_AW = DEF_RAM_AW
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] ACC  = ST_ACC;
    localparam logic [1:0] RSP  = ST_RSP;

    logic [1:0]    state;
    port_t         sel;
    port_t         last;
    port_t         win;
    logic          any_req;
    logic          oor;
    logic          cur_wr;
    logic          cur_oor;
    logic [AW-1:0] cur_a;
    logic [DW-1:0] cur_i;
    logic [DW-1:0] rsp_data;
    logic [DW-1:0] hold0;
    logic [DW-1:0] hold1;

    memarb_pick u_pick (
        .req0    (bus.req0),
        .req1    (bus.req1),
        .last    (last),
        .win     (win),
        .any_req (any_req)
    );

    // Route the winning port's request fields to the latch stage
    always_comb begin
        cur_wr = bus.wr0;
        cur_a  = bus.a0;
        cur_i  = bus.i0;
        if (win) begin
            cur_wr = bus.wr1;
            cur_a  = bus.a1;
            cur_i  = bus.i1;
        end
    end

    assign cur_oor  = |cur_a[AW-1:RAM_AW];
    assign rsp_data = oor ? '0 : bus.mo;

    // Read data is live from the RAM during RSP, otherwise the per-port hold register
    assign bus.o0 = (state == RSP && sel == 1'b0) ? rsp_data : hold0;
    assign bus.o1 = (state == RSP && sel == 1'b1) ? rsp_data : hold1;

    // Access sequencer: latch the winner in IDLE, drive the RAM in ACC, answer in RSP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 1'b0;
            oor      <= 1'b0;
            last     <= 1'b1;
            bus.mcs  <= 1'b0;
            bus.mwr  <= 1'b0;
            bus.ma   <= '0;
            bus.mi   <= '0;
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            bus.err0 <= 1'b0;
            bus.err1 <= 1'b0;
            hold0    <= '0;
            hold1    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel     <= win;
                        oor     <= cur_oor;
                        bus.mcs <= ~cur_oor;
                        bus.mwr <= cur_wr & ~cur_oor;
                        bus.ma  <= cur_a[RAM_AW-1:0];
                        bus.mi  <= cur_i;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    bus.mcs <= 1'b0;
                    bus.mwr <= 1'b0;
                    if (sel) begin
                        bus.ack1 <= 1'b1;
                        bus.err1 <= oor;
                    end else begin
                        bus.ack0 <= 1'b1;
                        bus.err0 <= oor;
                    end
                    state <= RSP;
                end
                RSP: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    bus.err0 <= 1'b0;
                    bus.err1 <= 1'b0;
                    if (sel) begin
                        hold1 <= rsp_data;
                    end else begin
                        hold0 <= rsp_data;
                    end
                    last  <= sel;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter with a
// behavioural 512x32 WRITE_FIRST RAM. Contention expectations follow the
// MEMARB_ROUND_ROBIN_EN macro.
module tb_mem_arbiter;
    import memarb_pkg::*;

    typedef struct {
        logic        port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] expO;
        logic        expErr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] expHold [2];
    logic        expLast;
    logic [31:0] ram [0:511];
    vec_t        vecs [7];

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous WRITE_FIRST block RAM model
    always @(posedge clk) begin
        if (bus.mcs) begin
            if (bus.mwr) begin
                ram[bus.ma] <= bus.mi;
                bus.mo      <= bus.mi;
            end else begin
                bus.mo <= ram[bus.ma];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic port, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        if (port) begin
            bus.req1 = 1'b1; bus.wr1 = wr; bus.a1 = addr; bus.i1 = data;
        end else begin
            bus.req0 = 1'b1; bus.wr0 = wr; bus.a0 = addr; bus.i0 = data;
        end
    endtask

    task automatic clearRequests();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    // One isolated access: checks ACC outputs, the RSP answer and the held result
    task automatic runAccess(input vec_t v);
        logic inWin;
        inWin = (v.addr[31:9] == 23'd0);
        @(negedge clk);
        applyStimulus(v.port, v.wr, v.addr, v.data);
        @(posedge clk); #1;
        applyStimulus(v.port, ~v.wr, ~v.addr, ~v.data);
        checkOutput("acc mcs", {31'd0, bus.mcs}, {31'd0, inWin});
        checkOutput("acc mwr", {31'd0, bus.mwr}, {31'd0, v.wr & inWin});
        checkOutput("acc ma", {23'd0, bus.ma}, {23'd0, v.addr[8:0]});
        if (v.wr && inWin) checkOutput("acc mi", bus.mi, v.data);
        @(posedge clk); #1;
        checkOutput("rsp ack", {31'd0, v.port ? bus.ack1 : bus.ack0}, 32'd1);
        checkOutput("rsp other ack", {31'd0, v.port ? bus.ack0 : bus.ack1}, 32'd0);
        checkOutput("rsp err", {31'd0, v.port ? bus.err1 : bus.err0}, {31'd0, v.expErr});
        checkOutput("rsp data", v.port ? bus.o1 : bus.o0, v.expO);
        checkOutput("other port hold", v.port ? bus.o0 : bus.o1, expHold[!v.port]);
        checkOutput("rsp mcs", {31'd0, bus.mcs}, 32'd0);
        clearRequests();
        expHold[v.port] = v.expO;
        expLast         = v.port;
        @(posedge clk); #1;
        checkOutput("post ack", {31'd0, v.port ? bus.ack1 : bus.ack0}, 32'd0);
        checkOutput("post hold", v.port ? bus.o1 : bus.o0, v.expO);
    endtask

    initial begin
        logic [31:0] wdata [2];
        logic        g;
        logic        seen;
        int          nAck;
        int          nMcs;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_C003, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_01FF, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_01FF, 32'h0000_0000, 32'h1234_5678, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};

        rst = 1'b1;
        bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.a0 = '0; bus.i0 = '0;
        bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.a1 = '0; bus.i1 = '0;
        expHold[0] = '0;
        expHold[1] = '0;
        expLast    = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset mcs", {31'd0, bus.mcs}, 32'd0);
        checkOutput("reset mwr", {31'd0, bus.mwr}, 32'd0);
        checkOutput("reset ma", {23'd0, bus.ma}, 32'd0);
        checkOutput("reset mi", bus.mi, 32'd0);
        checkOutput("reset acks", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        checkOutput("reset errs", {30'd0, bus.err1, bus.err0}, 32'd0);
        checkOutput("reset o0", bus.o0, 32'd0);
        checkOutput("reset o1", bus.o1, 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            $display("[TB] vector %0d", k);
            runAccess(vecs[k]);
        end

        // Reset during ACC of a port 0 write
        $display("[TB] reset mid-access");
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h0000_0030, 32'hCAFE_F00D);
        @(posedge clk); #1;
        checkOutput("abort acc mcs", {31'd0, bus.mcs}, 32'd1);
        checkOutput("abort acc mwr", {31'd0, bus.mwr}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort mcs async", {31'd0, bus.mcs}, 32'd0);
        checkOutput("abort mwr async", {31'd0, bus.mwr}, 32'd0);
        clearRequests();
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | bus.ack0 | bus.ack1;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen = seen | bus.ack0 | bus.ack1 | bus.mcs;
        end
        checkOutput("abort no ack", {31'd0, seen}, 32'd0);
        checkOutput("abort o0 cleared", bus.o0, 32'd0);
        expHold[0] = '0;
        expHold[1] = '0;
        expLast    = 1'b1;
        runAccess('{1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0});

        // Contention: both ports hold REQ across three grants, then port 0 backs off
        $display("[TB] contention");
        wdata[0] = 32'hA5A5_0000;
        wdata[1] = 32'h5A5A_1111;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h0000_0020, wdata[0]);
        applyStimulus(1'b1, 1'b1, 32'h0000_0021, wdata[1]);
        for (int k = 0; k < 3; k++) begin
            repeat ((k == 0) ? 2 : 3) @(posedge clk);
            #1;
`ifdef MEMARB_ROUND_ROBIN_EN
            g = ~expLast;
`else
            g = 1'b0;
`endif
            checkOutput("grant ack0", {31'd0, bus.ack0}, {31'd0, ~g});
            checkOutput("grant ack1", {31'd0, bus.ack1}, {31'd0, g});
            checkOutput("grant data", g ? bus.o1 : bus.o0, wdata[g]);
            expHold[g] = wdata[g];
            expLast    = g;
        end
        bus.req0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("late ack1", {31'd0, bus.ack1}, 32'd1);
        checkOutput("late ack0", {31'd0, bus.ack0}, 32'd0);
        clearRequests();
        expHold[1] = wdata[1];
        expLast    = 1'b1;
        @(posedge clk); #1;
        checkOutput("contention hold0", bus.o0, expHold[0]);
        checkOutput("contention hold1", bus.o1, expHold[1]);

        // Back-to-back reads with REQ0 held continuously
        $display("[TB] back-to-back");
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0000_0020, 32'h0);
        nAck = 0;
        nMcs = 0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (bus.ack0) nAck++;
            if (bus.mcs) nMcs++;
            checkOutput("b2b ack0 phase", {31'd0, bus.ack0}, {31'd0, (c % 3) == 2});
            if (bus.ack0 && bus.ack1) checkOutput("b2b both acks", 32'd1, 32'd0);
            if ((c % 3) == 2) checkOutput("b2b data", bus.o0, wdata[0]);
        end
        clearRequests();
        checkOutput("b2b ack count", nAck, 32'd3);
        checkOutput("b2b mcs count", nMcs, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
